uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per bit period (50 MHz / 115200 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries, power of two, range 2..256.
REQ-003 SHALL have parameter RTS_THRESH, default FIFO_DEPTH-2, occupancy at or above which rts_n deasserts.
REQ-004 clk  input  1  sole clock, all logic on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-007 data_bit_num  input  2  data bits: 00=5, 01=6, 10=7, 11=8.
REQ-008 stop_bit_num  input  1  0=one stop bit, 1=two stop bits.
REQ-009 parity_en  input  1  parity bit present when 1.
REQ-010 parity_type  input  1  0=even, 1=odd.
REQ-011 rd_en  input  1  pop the FIFO head.
REQ-012 rx_data  output  8  FIFO head data, zero-extended for widths below 8.
REQ-013 rx_perr / rx_ferr  output  1 each  parity / framing error flags stored with the head entry.
REQ-014 rx_empty  output  1  FIFO empty.
REQ-015 rx_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-016 rx_done  output  1  one-cycle pulse when a frame is written to the FIFO.
REQ-017 overrun  output  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.
REQ-018 rts_n  output  1  flow control, 0 = ready to receive.
REQ-019 break_det  output  1  one-cycle break-detect pulse.

Function
REQ-020 rx SHALL pass through a two-flop synchroniser (reset value 1) before any use.
REQ-021 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, with IDLE as the reset state.
REQ-022 IDLE->START on a synchronised falling edge of rx; data_bit_num, stop_bit_num, parity_en and parity_type SHALL be latched at that cycle and held for the frame.
REQ-023 START SHALL re-sample rx at CLKS_PER_BIT/2; if rx is high, return to IDLE (glitch rejected, no output), otherwise go to DATA.
REQ-024 DATA SHALL sample each bit every CLKS_PER_BIT cycles at mid-bit, LSB first, for the latched bit count, then go to PARITY if parity is enabled, else to STOP.
REQ-025 PARITY SHALL sample one bit; rx_perr is set if the XOR of the data bits and the parity bit is not 0 (even) or not 1 (odd).
REQ-026 STOP SHALL sample one or two stop bits; any low stop sample sets rx_ferr.
REQ-027 After the last stop sample the frame SHALL be written to the FIFO with both flags and rx_done pulsed in the same cycle, then the FSM returns to IDLE.
REQ-028 The FSM SHALL not re-arm in IDLE until rx has been sampled high.
REQ-029 Write while full SHALL drop the frame and pulse overrun instead of rx_done, unless rd_en is high in the same cycle, in which case both the read and the write occur.
REQ-030 rd_en while rx_empty SHALL be ignored, with no pointer or count change.
REQ-031 The FIFO SHALL be first-word-fall-through: rx_data and the flags are valid whenever rx_empty=0.
REQ-032 rts_n SHALL be registered: 1 when the next rx_count >= RTS_THRESH, else 0. Frames in flight SHALL still be received.
REQ-033 Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-034 While reset_n is low: FSM=IDLE, counters and pointers 0, rx_count=0, rx_empty=1, rx_data=0, flags 0, rx_done/overrun/break_det=0, rts_n=1.
REQ-035 rts_n SHALL go 0 on the first clk after release.
REQ-036 Reset asserted mid-frame SHALL abort the frame and clear the FIFO contents.

Configuration
REQ-037 With macro UART_RX_BREAK_DETECT_EN defined, a frame with all data, parity and stop samples low SHALL pulse break_det, SHALL not be written to the FIFO, and the FSM SHALL wait for rx high.
REQ-038 Without UART_RX_BREAK_DETECT_EN, break_det SHALL be tied 0 and such a frame SHALL be written with rx_ferr=1.

Structure
REQ-039 A shared package uart_pkg SHALL hold the FSM state enum, the data_bit_num encoding constants and the FIFO entry struct (data[7:0], perr, ferr).
REQ-040 The FIFO SHALL be a sub-module uart_sync_fifo, parameterised by depth and entry type.

Verification
REQ-041 8N1, rx frame 0xA5 -> rx_done after 9.5 bit periods; rx_data=0xA5, flags 0, rx_count=1.
REQ-042 7E2, data 0x35 sent with a wrong parity bit -> entry 0x35 with rx_perr=1, rx_ferr=0; then 5O1, data 0x1F -> entry 0x1F, flags 0.
REQ-043 Write 16 frames with FIFO_DEPTH=16 and no reads -> rts_n=1 from count 14; a 17th frame pulses overrun with count held at 16; 17th frame with rd_en at its write cycle -> no overrun, count 16.
REQ-044 0.3-bit low glitch on rx -> no rx_done, FSM back in IDLE; reset_n pulled low mid-DATA -> rx_empty=1, rts_n=1, next frame received correctly.
REQ-045 rx held low for 12 bit periods -> break_det pulse and no write (macro defined), or an entry with 0x00 and rx_ferr=1 (macro undefined).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART receiver: FSM states, data-width encoding and FIFO entry layout.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam logic [1:0] DataBits5 = 2'b00;
  localparam logic [1:0] DataBits6 = 2'b01;
  localparam logic [1:0] DataBits7 = 2'b10;
  localparam logic [1:0] DataBits8 = 2'b11;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } uart_entry_t;

  function automatic logic [3:0] data_bits(input logic [1:0] enc);
    case (enc)
      DataBits5: return 4'd5;
      DataBits6: return 4'd6;
      DataBits7: return 4'd7;
      default:   return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head reads as zero while empty.
module uart_sync_fifo #(
  parameter int unsigned Depth = 16,
  parameter type entry_t = logic [7:0]
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_en_i,
  input  entry_t                  wr_data_i,
  input  logic                    rd_en_i,
  output entry_t                  rd_data_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic [$clog2(Depth):0]  count_o,
  output logic [$clog2(Depth):0]  count_next_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] FullCount = (AW + 1)'(Depth);

  entry_t        mem_q [Depth];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_rd, do_wr;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FullCount);
  assign do_rd   = rd_en_i & ~empty_o;
  // A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
  assign do_wr   = wr_en_i & (~full_o | do_rd);
  assign count_o = count_q;

  always_comb begin
    count_next_o = count_q;
    if (do_wr && !do_rd) begin
      count_next_o = count_q + 1'b1;
    end else if (do_rd && !do_wr) begin
      count_next_o = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
      count_q <= count_next_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q] <= wr_data_i;
  end

  always_comb begin
    rd_data_o = '0;
    if (!empty_o) rd_data_o = mem_q[rptr_q];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, receive FIFO and RTS flow control.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned RTS_THRESH   = FIFO_DEPTH - 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rx,
  input  logic [1:0]                    data_bit_num,
  input  logic                          stop_bit_num,
  input  logic                          parity_en,
  input  logic                          parity_type,
  input  logic                          rd_en,
  output logic [7:0]                    rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  output logic                          rx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_done,
  output logic                          overrun,
  output logic                          rts_n,
  output logic                          break_det
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  logic rx_s1_q, rx_s2_q, rx_prev_q;
  uart_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [3:0] nbits_q, nbits_d;
  logic stop_idx_q, stop_idx_d, two_stop_q, two_stop_d;
  logic par_en_q, par_en_d, par_odd_q, par_odd_d;
  logic [7:0] data_q, data_d;
  logic par_acc_q, par_acc_d, perr_q, perr_d, ferr_q, ferr_d;
  logic any_high_q, any_high_d;
  logic frame_end, frame_wr, is_break, bit_tick;
  logic rx_done_q, overrun_q, rts_n_q;
  logic fifo_full;
  logic [$clog2(FIFO_DEPTH):0] count_next;
  uart_entry_t wr_entry, head;

  assign bit_tick = (cnt_q == BitLast);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    nbits_d    = nbits_q;
    stop_idx_d = stop_idx_q;
    two_stop_d = two_stop_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    data_d     = data_q;
    par_acc_d  = par_acc_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    any_high_d = any_high_q;
    frame_end  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Falling-edge start also enforces waiting for rx high after a frame or break.
        if (rx_prev_q && !rx_s2_q) begin
          state_d    = StStart;
          cnt_d      = '0;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          nbits_d    = data_bits(data_bit_num);
          two_stop_d = stop_bit_num;
          par_en_d   = parity_en;
          par_odd_d  = parity_type;
          data_d     = '0;
          par_acc_d  = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          any_high_d = 1'b0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          state_d = rx_s2_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_tick) begin
          cnt_d             = '0;
          data_d[bit_idx_q] = rx_s2_q;
          par_acc_d         = par_acc_q ^ rx_s2_q;
          any_high_d        = any_high_q | rx_s2_q;
          if ({1'b0, bit_idx_q} == nbits_q - 4'd1) begin
            state_d = par_en_q ? StParity : StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StParity: begin
        if (bit_tick) begin
          cnt_d      = '0;
          perr_d     = (par_acc_q ^ rx_s2_q) != par_odd_q;
          any_high_d = any_high_q | rx_s2_q;
          state_d    = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_tick) begin
          cnt_d      = '0;
          ferr_d     = ferr_q | ~rx_s2_q;
          any_high_d = any_high_q | rx_s2_q;
          if (two_stop_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            frame_end = 1'b1;
            state_d   = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic break_q;
  assign is_break = frame_end & ~any_high_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) break_q <= 1'b0;
    else          break_q <= is_break;
  end
  assign break_det = break_q;
`else
  assign is_break  = 1'b0;
  assign break_det = 1'b0;
`endif

  assign frame_wr = frame_end & ~is_break;
  assign wr_entry = '{data: data_q, perr: perr_q, ferr: ferr_d};

  uart_sync_fifo #(
    .Depth   (FIFO_DEPTH),
    .entry_t (uart_entry_t)
  ) u_fifo (
    .clk_i        (clk),
    .rst_ni       (reset_n),
    .wr_en_i      (frame_wr),
    .wr_data_i    (wr_entry),
    .rd_en_i      (rd_en),
    .rd_data_o    (head),
    .empty_o      (rx_empty),
    .full_o       (fifo_full),
    .count_o      (rx_count),
    .count_next_o (count_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      nbits_q    <= 4'd8;
      stop_idx_q <= 1'b0;
      two_stop_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      data_q     <= '0;
      par_acc_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      any_high_q <= 1'b0;
      rx_done_q  <= 1'b0;
      overrun_q  <= 1'b0;
      rts_n_q    <= 1'b1;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      nbits_q    <= nbits_d;
      stop_idx_q <= stop_idx_d;
      two_stop_q <= two_stop_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      data_q     <= data_d;
      par_acc_q  <= par_acc_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      any_high_q <= any_high_d;
      rx_done_q  <= frame_wr & (~fifo_full | rd_en);
      overrun_q  <= frame_wr & fifo_full & ~rd_en;
      rts_n_q    <= (32'(count_next) >= RTS_THRESH);
    end
  end

  assign rx_data = head.data;
  assign rx_perr = head.perr;
  assign rx_ferr = head.ferr;
  assign rx_done = rx_done_q;
  assign overrun = overrun_q;
  assign rts_n   = rts_n_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised self-checking bench for uart_rx_fifo against a queue-based frame model.
module tb_uart_rx_fifo;

  localparam int unsigned Cpb    = 16;
  localparam int unsigned Depth  = 16;
  localparam int unsigned Thresh = Depth - 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       rx = 1'b1;
  logic [1:0] data_bit_num = 2'b11;
  logic       stop_bit_num = 1'b0;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rx_data;
  logic       rx_perr, rx_ferr, rx_empty;
  logic [4:0] rx_count;
  logic       rx_done, overrun, rts_n, break_det;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0, ovr_cnt = 0, brk_cnt = 0;
  int exp_done = 0, exp_ovr = 0, exp_brk = 0;
  int pos_cyc = 0, last_done_cyc = 0;
  logic [9:0] model_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT (Cpb),
    .FIFO_DEPTH   (Depth)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .data_bit_num (data_bit_num),
    .stop_bit_num (stop_bit_num),
    .parity_en    (parity_en),
    .parity_type  (parity_type),
    .rd_en        (rd_en),
    .rx_data      (rx_data),
    .rx_perr      (rx_perr),
    .rx_ferr      (rx_ferr),
    .rx_empty     (rx_empty),
    .rx_count     (rx_count),
    .rx_done      (rx_done),
    .overrun      (overrun),
    .rts_n        (rts_n),
    .break_det    (break_det)
  );

  always @(posedge clk) pos_cyc <= pos_cyc + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= pos_cyc;
    end
    if (overrun)   ovr_cnt <= ovr_cnt + 1;
    if (break_det) brk_cnt <= brk_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (Cpb) @(negedge clk);
  endtask

  // Model: a frame lands in the FIFO unless it is a break (macro build) or the FIFO is full.
  task automatic model_frame(input logic [9:0] ent, input bit hi, input bit rd_at_end);
`ifdef UART_RX_BREAK_DETECT_EN
    if (!hi) begin
      exp_brk++;
      return;
    end
`endif
    if (rd_at_end && model_q.size() != 0) void'(model_q.pop_front());
    if (model_q.size() == Depth) begin
      exp_ovr++;
    end else begin
      model_q.push_back(ent);
      exp_done++;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit podd,
                            input bit two, input bit bad_par, input bit bad_stop,
                            input bit rd_at_end);
    logic [7:0] m;
    logic pbit;
    bit hi;
    m    = d & 8'((1 << nb) - 1);
    pbit = (^m) ^ podd ^ bad_par;
    hi   = (m != 0) || (pen && pbit) || !bad_stop || two;
    data_bit_num = 2'(nb - 5);
    parity_en    = pen;
    parity_type  = podd;
    stop_bit_num = two;
    fork
      begin
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(m[i]);
        if (pen) drive_bit(pbit);
        drive_bit(!bad_stop);
        if (two) drive_bit(1'b1);
        drive_bit(1'b1);
      end
      begin
        // Last stop sample of an 8N1 frame is taken on the 155th rising edge after the start bit.
        if (rd_at_end) begin
          repeat (154) @(negedge clk);
          rd_en = 1'b1;
          @(negedge clk);
          rd_en = 1'b0;
        end
      end
    join
    model_frame({m, pen && bad_par, bad_stop}, hi, rd_at_end);
  endtask

  task automatic pop_check(input string tag);
    if (model_q.size() == 0) begin
      check_eq({tag, "_empty"}, rx_empty, 1);
    end else begin
      check_eq({tag, "_entry"}, {rx_empty, rx_data, rx_perr, rx_ferr}, {1'b0, model_q[0]});
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      void'(model_q.pop_front());
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_count"}, rx_count, model_q.size());
    check_eq({tag, "_rts"}, rts_n, model_q.size() >= Thresh);
    check_eq({tag, "_done"}, done_cnt, exp_done);
  endtask

  initial begin
    int t0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_empty", rx_empty, 1);
    check_eq("rst_count", rx_count, 0);
    check_eq("rst_data", {rx_data, rx_perr, rx_ferr}, 0);
    check_eq("rst_pulses", {rx_done, overrun, break_det}, 0);
    check_eq("rst_rts", rts_n, 1);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rts_after_rst", rts_n, 0);
    repeat (4) @(negedge clk);

    // 8N1 0xA5 with latency measured from the start bit.
    t0 = pos_cyc;
    send_frame(8'hA5, 8, 0, 0, 0, 0, 0, 0);
    check_eq("lat_8n1", (last_done_cyc - t0 >= 148) && (last_done_cyc - t0 <= 160), 1);
    check_eq("a5_count", rx_count, 1);
    pop_check("a5");

    // 7E2 with a wrong parity bit, then 5O1.
    send_frame(8'h35, 7, 1, 0, 1, 1, 0, 0);
    send_frame(8'h1F, 5, 1, 1, 0, 0, 0, 0);
    check_state("fmt");
    pop_check("7e2");
    pop_check("5o1");

    for (int k = 0; k < 24; k++) begin
      int nb;
      bit pen;
      nb  = 5 + int'($urandom_range(0, 3));
      pen = 1'($urandom_range(0, 1));
      send_frame(8'($urandom), nb, pen, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 pen && ($urandom_range(0, 3) == 0), $urandom_range(0, 4) == 0, 0);
      check_state("rand");
      if ($urandom_range(0, 1) == 1) begin
        while (model_q.size() != 0) pop_check("rand_pop");
      end
    end
    while (model_q.size() != 0) pop_check("drain");

    // Fill to full, overrun, then a write that coincides with a read.
    for (int k = 0; k < Depth; k++) begin
      send_frame(8'($urandom), 8, 0, 0, 0, 0, 0, 0);
      check_eq("fill_count", rx_count, model_q.size());
      check_eq("fill_rts", rts_n, model_q.size() >= Thresh);
    end
    send_frame(8'h5A, 8, 0, 0, 0, 0, 0, 0);
    check_eq("ovr_cnt", ovr_cnt, exp_ovr);
    check_eq("ovr_count", rx_count, Depth);
    send_frame(8'hC3, 8, 0, 0, 0, 0, 0, 1);
    check_eq("rdwr_ovr", ovr_cnt, exp_ovr);
    check_state("rdwr");
    pop_check("rdwr_head");

    // Short low glitch is rejected.
    data_bit_num = 2'b11;
    parity_en    = 1'b0;
    stop_bit_num = 1'b0;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3 * Cpb) @(negedge clk);
    check_state("glitch");

    // Reset in the middle of the data bits.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    reset_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    check_eq("midrst_empty", rx_empty, 1);
    check_eq("midrst_rts", rts_n, 1);
    check_eq("midrst_count", rx_count, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_q.delete();
    repeat (2 * Cpb) @(negedge clk);
    send_frame(8'h3C, 8, 0, 0, 0, 0, 0, 0);
    check_state("post_rst");
    pop_check("post_rst");

    // Line held low for 12 bit periods.
    rx = 1'b0;
    repeat (12 * Cpb) @(negedge clk);
    rx = 1'b1;
    repeat (2 * Cpb) @(negedge clk);
    model_frame(10'b00000000_0_1, 1'b0, 1'b0);
    check_state("break");
    pop_check("break");

    check_eq("total_done", done_cnt, exp_done);
    check_eq("total_ovr", ovr_cnt, exp_ovr);
    check_eq("total_brk", brk_cnt, exp_brk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
